switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
//
// PURPOSE
//   Input-side counterpart to the LED output path: conditions the raw board
//   inputs (SW2 DIP switches, SW1 pushbutton) before the logic uses them.
//   - Synchronises each bit into the clk domain.
//   - Debounces each bit with its own stability counter.
//   - Presents clean levels plus single-cycle rise/fall strobes.
//   - Sits between the top-level pins and the mode/clock-select logic;
//     sw_settled qualifies the levels after power-up.
//
// PARAMETERS
//   WIDTH        5         number of input bits (DIPSW[3:0] + pushbutton)
//   CLK_FREQ     12000000  clk frequency in Hz
//   DEBOUNCE_MS  10        required stable time in ms
//   DB_CYCLES    (derived) CLK_FREQ/1000*DEBOUNCE_MS; localparam, must be >= 2
//
// PORTS
//   clk         in   1      system clock (12 MHz, osc or X1)
//   rstn        in   1      asynchronous, active-low reset
//   sw_raw      in   WIDTH  raw asynchronous switch inputs
//   sw_level    out  WIDTH  debounced level
//   sw_rise     out  WIDTH  1-cycle pulse per bit on debounced 0->1
//   sw_fall     out  WIDTH  1-cycle pulse per bit on debounced 1->0
//   sw_change   out  1      1-cycle pulse, OR of all rise|fall bits
//   sw_settled  out  1      1 once initial debounce done; stays 1 until reset
//
// BEHAVIOUR
// - Reset (rstn=0, async):
//   - sync flops, sw_level, rise, fall, change, settled all = 0.
//   - All counters = 0; FSM = INIT.
// - Sync: 2-flop synchroniser per bit, sw_raw -> s1 -> s2. Logic uses s2 only.
// - FSM INIT:
//   - sw_level <= s2 every cycle; no rise/fall/change pulses.
//   - Global counter gcnt counts cycles with s2 == s2 of previous cycle (all bits).
//   - Any bit differing from the previous cycle clears gcnt to 0.
//   - When gcnt == DB_CYCLES-1: next cycle FSM = RUN, sw_settled = 1.
//     sw_level holds the stable value; no pulses are emitted on entry.
// - FSM RUN, per bit i, counter cnt[i] of width clog2(DB_CYCLES):
//   - If s2[i] == sw_level[i]: cnt[i] <= 0.
//   - Else if cnt[i] == DB_CYCLES-1: sw_level[i] <= s2[i], cnt[i] <= 0,
//     rise[i]/fall[i] asserted for exactly that one registered cycle.
//   - Else: cnt[i] <= cnt[i]+1.
// - Latency: clean edge on sw_raw -> sw_level/pulse updates DB_CYCLES+2 clk
//   edges later.
// - Bounce: any single cycle with s2 == sw_level restarts that bit's count.
//   A glitch shorter than DB_CYCLES never reaches sw_level.
// - Simultaneous: bits are independent. Several bits may pulse in the same
//   cycle; sw_change is a single pulse in that cycle.
// - Counters saturate by construction (cleared on commit); no wrap is possible.
// - Reset mid-count: all state cleared and the FSM re-enters INIT.
//   No pulse is emitted after reset until RUN is reached and a new change is
//   debounced.
// - Outputs are registered; no combinational path from sw_raw.
// - rise/fall/change are always 0 while sw_settled = 0.
//
// TESTING (CLK_FREQ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4)
// 1. Power-up: sw_raw=5'b01010 held from reset release.
//    -> sw_settled=1 and sw_level=01010 after 4+2 cycles of stability;
//       zero pulses throughout.
// 2. RUN, bit0 0->1 clean.
//    -> sw_level[0]=1 and sw_rise=00001, sw_change=1 for 1 cycle,
//       exactly 6 edges after the input edge.
// 3. Bit2 bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle).
//    -> single sw_rise[2] only after the final 4-cycle stable run; never two pulses.
// 4. 3-cycle glitch on bit4 (1 then back to 0).
//    -> sw_level[4] stays 0, no pulse, cnt[4] returns to 0.
// 5. Bits 1 and 3 toggle the same cycle (1->0, 0->1).
//    -> sw_fall=00010 and sw_rise=01000 in the same cycle, one sw_change pulse.
// 6. rstn low for 1 cycle during cnt[0]=2.
//    -> all outputs 0 immediately, FSM back in INIT, no pulse until a new
//       debounced change.

Source files
------------

// File: rtl/switch_debounce.sv
// Board switch conditioner: two-flop sync, per-bit debounce,
// registered levels plus single-cycle rise/fall/change strobes.
module switch_debounce #(
    parameter int WIDTH       = 5,
    parameter int CLK_FREQ    = 12000000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change,
    output logic             sw_settled
);

    localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CW        = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]         s1, s2;
    logic [WIDTH-1:0]         level_n, rise_n, fall_n;
    logic [CW-1:0]            gcnt, gcnt_n;
    logic [WIDTH-1:0][CW-1:0] cnt, cnt_n;
    logic                     settled_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= INIT;
            gcnt       <= '0;
            cnt        <= '0;
            sw_level   <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_change  <= 1'b0;
            sw_settled <= 1'b0;
        end else begin
            state      <= state_n;
            gcnt       <= gcnt_n;
            cnt        <= cnt_n;
            sw_level   <= level_n;
            sw_rise    <= rise_n;
            sw_fall    <= fall_n;
            sw_change  <= |(rise_n | fall_n);
            sw_settled <= settled_n;
        end
    end

    // In INIT, sw_level doubles as the previous-cycle copy of s2.
    always_comb begin
        state_n   = state;
        gcnt_n    = gcnt;
        cnt_n     = cnt;
        level_n   = sw_level;
        rise_n    = '0;
        fall_n    = '0;
        settled_n = sw_settled;
        unique case (state)
            INIT: begin
                level_n = s2;
                cnt_n   = '0;
                if (s2 != sw_level) begin
                    gcnt_n = '0;
                end else if (gcnt == LAST) begin
                    gcnt_n    = '0;
                    state_n   = RUN;
                    settled_n = 1'b1;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (s2[i] == sw_level[i]) begin
                        cnt_n[i] = '0;
                    end else if (cnt[i] == LAST) begin
                        level_n[i] = s2[i];
                        cnt_n[i]   = '0;
                        rise_n[i]  = s2[i];
                        fall_n[i]  = ~s2[i];
                    end else begin
                        cnt_n[i] = cnt[i] + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DB_CYCLES = 4.
module tb_switch_debounce;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] sw_raw;
    logic [4:0] sw_level, sw_rise, sw_fall;
    logic       sw_change, sw_settled;

    int tests = 0;
    int fails = 0;
    int bad_pulses = 0;
    int n;
    int at;
    int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

    switch_debounce #(
        .WIDTH(5),
        .CLK_FREQ(1000),
        .DEBOUNCE_MS(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sw_raw(sw_raw),
        .sw_level(sw_level),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_change(sw_change),
        .sw_settled(sw_settled)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!sw_settled && (sw_change || (|sw_rise) || (|sw_fall)))
            bad_pulses++;

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: power-up
        rstn   = 1'b0;
        sw_raw = 5'b01010;
        tick(2);
        chk("rst_level", 32'(sw_level), 32'h0);
        chk("rst_settled", 32'(sw_settled), 32'h0);
        rstn = 1'b1;
        tick(5);
        chk("init_unsettled", 32'(sw_settled), 32'h0);
        tick(2);
        chk("init_settled", 32'(sw_settled), 32'h1);
        chk("init_level", 32'(sw_level), 32'b01010);

        // 2: clean rise on bit0
        sw_raw = 5'b01011;
        tick(5);
        chk("b0_level_early", 32'(sw_level), 32'b01010);
        chk("b0_rise_early", 32'(sw_rise), 32'h0);
        tick();
        chk("b0_level", 32'(sw_level), 32'b01011);
        chk("b0_rise", 32'(sw_rise), 32'b00001);
        chk("b0_change", 32'(sw_change), 32'h1);
        tick();
        chk("b0_rise_end", 32'(sw_rise), 32'h0);
        chk("b0_change_end", 32'(sw_change), 32'h0);

        // 3: bounce on bit2
        n  = 0;
        at = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 9) sw_raw[2] = pat[k][0];
            tick();
            if (sw_rise[2]) begin
                n++;
                at = k + 1;
            end
        end
        chk("b2_pulses", 32'(n), 32'd1);
        chk("b2_pulse_edge", 32'(at), 32'd11);
        chk("b2_level", 32'(sw_level), 32'b01111);

        // 4: 3-cycle glitch on bit4
        n = 0;
        sw_raw[4] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (sw_change) n++;
        end
        sw_raw[4] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (sw_change) n++;
        end
        chk("b4_cnt_peak", 32'(dut.cnt[4]), 32'd3);
        tick();
        chk("b4_cnt_clear", 32'(dut.cnt[4]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (sw_change) n++;
        end
        chk("b4_pulses", 32'(n), 32'd0);
        chk("b4_level", 32'(sw_level), 32'b01111);

        // 5: bit1 falls and bit3 rises together
        sw_raw = 5'b00111;
        tick(8);
        chk("b3_prep_level", 32'(sw_level), 32'b00111);
        sw_raw = 5'b01101;
        tick(5);
        chk("dual_change_early", 32'(sw_change), 32'h0);
        tick();
        chk("dual_rise", 32'(sw_rise), 32'b01000);
        chk("dual_fall", 32'(sw_fall), 32'b00010);
        chk("dual_change", 32'(sw_change), 32'h1);
        chk("dual_level", 32'(sw_level), 32'b01101);
        tick();
        chk("dual_change_end", 32'(sw_change), 32'h0);

        // 6: reset mid-count
        sw_raw = 5'b01100;
        tick(4);
        chk("mid_cnt0", 32'(dut.cnt[0]), 32'd2);
        rstn = 1'b0;
        #1;
        chk("mid_rst_level", 32'(sw_level), 32'h0);
        chk("mid_rst_settled", 32'(sw_settled), 32'h0);
        chk("mid_rst_pulses", 32'({sw_rise, sw_fall, sw_change}), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sw_change) n++;
        end
        chk("post_rst_pulses", 32'(n), 32'd0);
        chk("post_rst_settled", 32'(sw_settled), 32'h1);
        chk("post_rst_level", 32'(sw_level), 32'b01100);
        chk("unsettled_pulses", 32'(bad_pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
